// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: zero-latency hit path, single-line
// refill over a req/ack handshake while the PC is held via stall_o.
module icache_ctrl #(
   parameter int unsigned LINE_NUM = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         req_i,
   input  logic [31:0]  pc_i,
   input  logic         flush_i,
   output logic [31:0]  instr_o,
   output logic         stall_o,
   output logic         mem_req_o,
   output logic [31:0]  mem_addr_o,
   input  logic         mem_ack_i,
   input  logic [127:0] mem_data_i,
   output logic [31:0]  miss_cnt_o,
   output logic [31:0]  hit_cnt_o
);

   localparam int unsigned IDX_W = $clog2(LINE_NUM);
   localparam int unsigned TAG_W = 28 - IDX_W;

   typedef enum logic [1:0] {
      IDLE,
      MISS,
      REFILL
   } state_t;

   state_t state_q, state_d;

   logic [127:0]        data_q [LINE_NUM];
   logic [TAG_W-1:0]    tag_q  [LINE_NUM];
   logic [LINE_NUM-1:0] valid_q;
   logic [27:0]         line_q;
   logic [31:0]         hit_cnt_q, miss_cnt_q;

   logic [IDX_W-1:0] idx, fill_idx;
   logic [TAG_W-1:0] tag, fill_tag;
   logic [127:0]     line_sel;
   logic [31:0]      word_sel;
   logic             hit;
   logic             cnt_hit, cnt_miss, latch_line, fill;
   logic             unused_pc_bits;

   assign idx            = pc_i[4+IDX_W-1:4];
   assign tag            = pc_i[31:4+IDX_W];
   assign fill_idx       = line_q[IDX_W-1:0];
   assign fill_tag       = line_q[27:IDX_W];
   assign unused_pc_bits = ^pc_i[1:0];

   assign line_sel = data_q[idx];
   assign hit      = req_i && valid_q[idx] && (tag_q[idx] == tag);

   always_comb begin
      word_sel = line_sel[31:0];
      case (pc_i[3:2])
         2'd1:    word_sel = line_sel[63:32];
         2'd2:    word_sel = line_sel[95:64];
         2'd3:    word_sel = line_sel[127:96];
         default: word_sel = line_sel[31:0];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      instr_o    = '0;
      stall_o    = 1'b0;
      mem_req_o  = 1'b0;
      mem_addr_o = '0;
      cnt_hit    = 1'b0;
      cnt_miss   = 1'b0;
      latch_line = 1'b0;
      fill       = 1'b0;
      case (state_q)
         IDLE: begin
            if (hit) begin
               instr_o = word_sel;
               cnt_hit = 1'b1;
            end else if (req_i) begin
               stall_o    = 1'b1;
               cnt_miss   = 1'b1;
               latch_line = 1'b1;
               state_d    = MISS;
            end
         end
         MISS: begin
            stall_o    = 1'b1;
            mem_req_o  = 1'b1;
            mem_addr_o = {line_q, 4'b0};
            if (mem_ack_i) begin
               fill    = 1'b1;
               state_d = REFILL;
            end
         end
         REFILL: begin
            stall_o = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Flush is applied after the fill so a coincident flush leaves the line invalid.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         line_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (latch_line) line_q <= pc_i[31:4];
         if (fill) valid_q[fill_idx] <= 1'b1;
         if (flush_i) valid_q <= '0;
         if (cnt_hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (cnt_miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill) begin
         data_q[fill_idx] <= mem_data_i;
         tag_q[fill_idx]  <= fill_tag;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: transaction-level cache model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_icache_ctrl;

   localparam int unsigned LINES = 32;
   localparam int unsigned IDXB  = $clog2(LINES);
   localparam logic [31:0] W0 = 32'h2001_0005;
   localparam logic [31:0] W1 = 32'h1111_1111;
   localparam logic [31:0] W2 = 32'h2222_2222;
   localparam logic [31:0] W3 = 32'h3333_3333;

   logic         clk = 1'b0, rst = 1'b0, req = 1'b0, flush = 1'b0, ack = 1'b0;
   logic [31:0]  pc = '0;
   logic [127:0] mdata = '0;
   logic [31:0]  instr, mem_addr, miss_cnt, hit_cnt;
   logic         stall, mem_req;

   icache_ctrl #(.LINE_NUM(LINES)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .pc_i(pc), .flush_i(flush),
      .instr_o(instr), .stall_o(stall), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
      .mem_ack_i(ack), .mem_data_i(mdata), .miss_cnt_o(miss_cnt), .hit_cnt_o(hit_cnt)
   );

   always #5 clk = ~clk;

   // Cache model: which line address each slot holds, plus an outstanding-refill flag.
   bit   [LINES-1:0] m_valid;
   logic [27:0]      m_lineaddr [LINES];
   logic [127:0]     m_data     [LINES];
   bit               m_pending, m_bubble;
   logic [27:0]      m_line;
   logic [31:0]      m_hits, m_misses;

   int n_checks = 0, n_err = 0, stall_cycles = 0;
   int ack_lat = 0, wait_cnt = 0;
   bit chk_en = 0, fixed_data = 0, flush_on_ack = 0, spurious_ack = 0, rand_lat = 0;
   logic        exp_stall;
   logic [31:0] exp_instr;

   function automatic bit m_lookup(input logic [31:0] a);
      return m_valid[a[4 +: IDXB]] && (m_lineaddr[a[4 +: IDXB]] === a[31:4]);
   endfunction

   function automatic logic [31:0] m_word(input logic [31:0] a);
      logic [127:0] ln;
      ln = m_data[a[4 +: IDXB]];
      return ln[32*a[3:2] +: 32];
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid   <= '0;
         m_pending <= 1'b0;
         m_bubble  <= 1'b0;
         m_hits    <= '0;
         m_misses  <= '0;
      end else begin
         if (m_pending) begin
            if (ack) begin
               m_lineaddr[m_line[IDXB-1:0]] <= m_line;
               m_data[m_line[IDXB-1:0]]     <= mdata;
               m_valid[m_line[IDXB-1:0]]    <= 1'b1;
               m_pending <= 1'b0;
               m_bubble  <= 1'b1;
            end
         end else if (m_bubble) begin
            m_bubble <= 1'b0;
         end else if (req) begin
            if (m_lookup(pc)) m_hits <= sat_inc(m_hits);
            else begin
               m_misses  <= sat_inc(m_misses);
               m_line    <= pc[31:4];
               m_pending <= 1'b1;
            end
         end
         if (flush) m_valid <= '0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         exp_stall = m_pending || m_bubble || (req && !m_lookup(pc));
         exp_instr = (!exp_stall && req) ? m_word(pc) : 32'h0;
         check("stall_o", 32'(stall), 32'(exp_stall));
         check("instr_o", instr, exp_instr);
         check("mem_req_o", 32'(mem_req), 32'(m_pending));
         check("mem_addr_o", mem_addr, m_pending ? {m_line, 4'b0} : 32'h0);
         check("hit_cnt_o", hit_cnt, m_hits);
         check("miss_cnt_o", miss_cnt, m_misses);
         if (stall) stall_cycles++;
      end
   end

   // Memory responder is driven from the model's view of the outstanding refill.
   task automatic cycle();
      if (rand_lat && m_pending && wait_cnt == 0) ack_lat = $urandom_range(0, 3);
      if (m_pending) begin
         ack = (wait_cnt >= ack_lat);
         wait_cnt++;
      end else begin
         ack = spurious_ack;
         wait_cnt = 0;
      end
      if (flush_on_ack) flush = ack && m_pending;
      mdata = fixed_data ? {W3, W2, W1, W0} : {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk);
      #1;
   endtask

   task automatic run_access(input logic [31:0] a);
      req = 1'b1;
      pc  = a;
      cycle();
      for (int k = 0; k < 20 && (m_pending || m_bubble); k++) cycle();
      check("access_timeout", 32'(m_pending | m_bubble), 32'h0);
   endtask

   initial begin
      #150000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2 rst = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hit_cnt", hit_cnt, 32'h0);
      check("rst_miss_cnt", miss_cnt, 32'h0);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_stall", 32'(stall), 32'h0);
      rst = 1'b0;

      // Cold miss, acknowledged in the third MISS cycle
      fixed_data = 1'b1;
      ack_lat = 2;
      stall_cycles = 0;
      req = 1'b1;
      pc = 32'h0000_0040;
      repeat (5) cycle();
      check("cold_stall_cycles", 32'(stall_cycles), 32'd5);
      check("cold_instr", instr, W0);
      cycle();
      check("cold_miss_cnt", miss_cnt, 32'd1);
      check("cold_hit_cnt", hit_cnt, 32'd1);

      pc = 32'h44; #1; check("hit_w1", instr, W1); cycle();
      pc = 32'h48; #1; check("hit_w2", instr, W2); cycle();
      pc = 32'h4C; #1; check("hit_w3", instr, W3); cycle();
      check("hits_in_line_cnt", hit_cnt, 32'd4);

      ack_lat = 1;
      run_access(32'h240);
      run_access(32'h40);
      check("conflict_miss_cnt", miss_cnt, 32'd3);

      ack_lat = 0;
      stall_cycles = 0;
      run_access(32'h80);
      check("zero_wait_stall_cycles", 32'(stall_cycles), 32'd3);
      check("zero_wait_instr", instr, W0);
      cycle();

      // Flush in IDLE keeps the same-cycle hit, invalidates afterwards
      pc = 32'h80; flush = 1'b1;
      #1; check("flush_same_cycle_hit", instr, W0);
      cycle();
      flush = 1'b0;
      pc = 32'h40;
      #1; check("flush_then_miss", 32'(stall), 32'h1);
      run_access(32'h40);
      cycle();

      ack_lat = 1;
      flush_on_ack = 1'b1;
      run_access(32'hC0);
      flush_on_ack = 1'b0;
      flush = 1'b0;
      #1; check("flush_ack_still_misses", 32'(stall), 32'h1);
      run_access(32'hC0);
      cycle();

      // Asynchronous reset in the middle of a refill
      ack_lat = 3;
      req = 1'b1;
      pc = 32'h100;
      cycle();
      cycle();
      check("midmiss_req_before_rst", 32'(mem_req), 32'h1);
      rst = 1'b1;
      #1;
      check("midmiss_req_async_drop", 32'(mem_req), 32'h0);
      check("midmiss_addr_zero", mem_addr, 32'h0);
      cycle();
      rst = 1'b0;
      req = 1'b0;
      spurious_ack = 1'b1;
      cycle();
      spurious_ack = 1'b0;
      check("post_rst_hit_cnt", hit_cnt, 32'h0);
      check("post_rst_miss_cnt", miss_cnt, 32'h0);
      req = 1'b1;
      pc = 32'h100;
      #1; check("post_rst_first_miss", 32'(stall), 32'h1);
      run_access(32'h100);
      cycle();
      check("post_rst_miss_one", miss_cnt, 32'd1);

      // Randomized traffic over a small address set to mix hits, conflicts and flushes
      fixed_data = 1'b0;
      rand_lat = 1'b1;
      repeat (800) begin
         req   = ($urandom_range(0, 9) != 0);
         pc    = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 9) |
                 (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
         flush = ($urandom_range(0, 39) == 0);
         cycle();
      end
      flush = 1'b0;
      req = 1'b0;
      repeat (6) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
